// File: rtl/sync_sram.sv
// sync_sram: 4096-entry user table with four independently accessed fields
// (pass, count, admin, lock). Reads are registered with one clock of latency.
// Reset restores the whole table in a single edge: each field keeps a
// per-entry "written since reset" bit, and an entry that has not been
// written returns its reset default instead of the raw storage contents.
// This lets the storage arrays stay reset-free.
module sync_sram (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        pass_rw,
  input  logic        admin_rw,
  input  logic        lock_rw,
  input  logic        count_rw,
  input  logic [11:0] addr,
  input  logic [15:0] pass_in,
  input  logic [3:0]  count_in,
  input  logic        admin_in,
  input  logic        lock_in,
  output logic [15:0] pass_out,
  output logic [3:0]  count_out,
  output logic        admin_out,
  output logic        lock_out
);

  localparam logic [11:0] ADMIN_ADDR    = 12'h123;
  localparam logic [15:0] ADMIN_PASS    = 16'h1234;
  localparam logic [15:0] UNASSIGN_PASS = 16'hFFFF;

  logic [15:0] pass_mem  [4096];
  logic [3:0]  count_mem [4096];
  logic        admin_mem [4096];
  logic        lock_mem  [4096];

  logic [4095:0] pass_vld_q,  pass_vld_d;
  logic [4095:0] count_vld_q, count_vld_d;
  logic [4095:0] admin_vld_q, admin_vld_d;
  logic [4095:0] lock_vld_q,  lock_vld_d;

  logic [15:0] pass_out_q,  pass_out_d;
  logic [3:0]  count_out_q, count_out_d;
  logic        admin_out_q, admin_out_d;
  logic        lock_out_q,  lock_out_d;

  logic        is_admin;
  logic        pass_we, count_we, admin_we, lock_we;
  logic [15:0] pass_rd;
  logic [3:0]  count_rd;
  logic        admin_rd, lock_rd;

  assign is_admin = (addr == ADMIN_ADDR);

  // A write in a reset cycle is dropped, so reset gates every write enable.
  assign pass_we  = cs & pass_rw  & ~rst;
  assign count_we = cs & count_rw & ~rst;
  assign admin_we = cs & admin_rw & ~rst;
  assign lock_we  = cs & lock_rw  & ~rst;

  // Read data: stored value if written since reset, otherwise reset default.
  always_comb begin
    pass_rd  = is_admin ? ADMIN_PASS : UNASSIGN_PASS;
    count_rd = 4'h0;
    admin_rd = is_admin;
    lock_rd  = ~is_admin;
    if (pass_vld_q[addr])  pass_rd  = pass_mem[addr];
    if (count_vld_q[addr]) count_rd = count_mem[addr];
    if (admin_vld_q[addr]) admin_rd = admin_mem[addr];
    if (lock_vld_q[addr])  lock_rd  = lock_mem[addr];
  end

  // Next state of valid bits and output registers; each field is independent.
  always_comb begin
    pass_vld_d  = pass_vld_q;
    count_vld_d = count_vld_q;
    admin_vld_d = admin_vld_q;
    lock_vld_d  = lock_vld_q;
    pass_out_d  = pass_out_q;
    count_out_d = count_out_q;
    admin_out_d = admin_out_q;
    lock_out_d  = lock_out_q;
    if (cs) begin
      if (pass_rw)  pass_vld_d[addr]  = 1'b1;
      else          pass_out_d        = pass_rd;
      if (count_rw) count_vld_d[addr] = 1'b1;
      else          count_out_d       = count_rd;
      if (admin_rw) admin_vld_d[addr] = 1'b1;
      else          admin_out_d       = admin_rd;
      if (lock_rw)  lock_vld_d[addr]  = 1'b1;
      else          lock_out_d        = lock_rd;
    end
  end

  // Register update; reset clears outputs and marks every entry as default.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_vld_q  <= '0;
      count_vld_q <= '0;
      admin_vld_q <= '0;
      lock_vld_q  <= '0;
      pass_out_q  <= '0;
      count_out_q <= '0;
      admin_out_q <= 1'b0;
      lock_out_q  <= 1'b0;
    end else begin
      pass_vld_q  <= pass_vld_d;
      count_vld_q <= count_vld_d;
      admin_vld_q <= admin_vld_d;
      lock_vld_q  <= lock_vld_d;
      pass_out_q  <= pass_out_d;
      count_out_q <= count_out_d;
      admin_out_q <= admin_out_d;
      lock_out_q  <= lock_out_d;
    end
  end

  // Reset-free storage arrays, written verbatim.
  always_ff @(posedge clk) begin
    if (pass_we)  pass_mem[addr]  <= pass_in;
    if (count_we) count_mem[addr] <= count_in;
    if (admin_we) admin_mem[addr] <= admin_in;
    if (lock_we)  lock_mem[addr]  <= lock_in;
  end

  assign pass_out  = pass_out_q;
  assign count_out = count_out_q;
  assign admin_out = admin_out_q;
  assign lock_out  = lock_out_q;

endmodule

// File: tb/tb_sync_sram.sv
// Testbench for sync_sram: directed vector table, a few hand-written
// sequences, then randomized traffic checked against a table model.
module tb_sync_sram;

  logic        clk = 1'b0;
  logic        rst, cs, pass_rw, admin_rw, lock_rw, count_rw;
  logic [11:0] addr;
  logic [15:0] pass_in;
  logic [3:0]  count_in;
  logic        admin_in, lock_in;
  logic [15:0] pass_out;
  logic [3:0]  count_out;
  logic        admin_out, lock_out;

  int n_checks = 0;
  int n_fail   = 0;

  sync_sram dut (
    .clk(clk), .rst(rst), .cs(cs),
    .pass_rw(pass_rw), .admin_rw(admin_rw), .lock_rw(lock_rw), .count_rw(count_rw),
    .addr(addr), .pass_in(pass_in), .count_in(count_in),
    .admin_in(admin_in), .lock_in(lock_in),
    .pass_out(pass_out), .count_out(count_out),
    .admin_out(admin_out), .lock_out(lock_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, cs, prw, crw, arw, lrw;
    logic [11:0] addr;
    logic [15:0] pin;
    logic [3:0]  cin;
    logic        ain, lin;
    logic [15:0] e_pass;
    logic [3:0]  e_count;
    logic        e_admin, e_lock;
  } vec_t;

  vec_t vecs [20];

  // Reference model: plain arrays plus output registers.
  logic [15:0] m_pass  [4096];
  logic [3:0]  m_count [4096];
  logic        m_admin [4096];
  logic        m_lock  [4096];
  logic [15:0] m_pout;
  logic [3:0]  m_cout;
  logic        m_aout, m_lout;

  function automatic vec_t mk(input logic r, input logic c,
                              input logic p, input logic cn, input logic a, input logic l,
                              input logic [11:0] ad, input logic [15:0] pi, input logic [3:0] ci,
                              input logic ai, input logic li,
                              input logic [15:0] ep, input logic [3:0] ec,
                              input logic ea, input logic el);
    vec_t v;
    v.rst = r; v.cs = c; v.prw = p; v.crw = cn; v.arw = a; v.lrw = l;
    v.addr = ad; v.pin = pi; v.cin = ci; v.ain = ai; v.lin = li;
    v.e_pass = ep; v.e_count = ec; v.e_admin = ea; v.e_lock = el;
    return v;
  endfunction

  task automatic drive(input logic r, input logic c, input logic p, input logic cn,
                       input logic a, input logic l, input logic [11:0] ad,
                       input logic [15:0] pi, input logic [3:0] ci,
                       input logic ai, input logic li);
    @(negedge clk);
    rst = r; cs = c; pass_rw = p; count_rw = cn; admin_rw = a; lock_rw = l;
    addr = ad; pass_in = pi; count_in = ci; admin_in = ai; lock_in = li;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] ep, input logic [3:0] ec,
                       input logic ea, input logic el);
    n_checks++;
    if ({pass_out, count_out, admin_out, lock_out} !== {ep, ec, ea, el}) begin
      n_fail++;
      $display("FAIL %s: got pass=%h count=%h admin=%b lock=%b, want pass=%h count=%h admin=%b lock=%b",
               name, pass_out, count_out, admin_out, lock_out, ep, ec, ea, el);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4096; i++) begin
      m_pass[i]  = (i == 'h123) ? 16'h1234 : 16'hFFFF;
      m_count[i] = 4'h0;
      m_admin[i] = (i == 'h123);
      m_lock[i]  = (i != 'h123);
    end
    m_pout = '0; m_cout = '0; m_aout = 1'b0; m_lout = 1'b0;
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
    end else if (cs) begin
      if (pass_rw)  m_pass[addr]  = pass_in;  else m_pout = m_pass[addr];
      if (count_rw) m_count[addr] = count_in; else m_cout = m_count[addr];
      if (admin_rw) m_admin[addr] = admin_in; else m_aout = m_admin[addr];
      if (lock_rw)  m_lock[addr]  = lock_in;  else m_lout = m_lock[addr];
    end
  endfunction

  initial begin
    rst = 1'b1; cs = 1'b0; pass_rw = 1'b0; count_rw = 1'b0; admin_rw = 1'b0; lock_rw = 1'b0;
    addr = '0; pass_in = '0; count_in = '0; admin_in = 1'b0; lock_in = 1'b0;

    //            rst cs  prw crw arw lrw addr     pin       cin   ain  lin   e_pass    e_cnt e_adm e_lck
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 4'h0, 0, 0, 16'h0000, 4'h0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 12'h123, 16'h0000, 4'h0, 0, 0, 16'h1234, 4'h0, 1, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 12'h456, 16'h0000, 4'h0, 0, 0, 16'hFFFF, 4'h0, 0, 1);
    vecs[3]  = mk(0, 1, 1, 1, 1, 1, 12'h456, 16'h9876, 4'h0, 0, 0, 16'hFFFF, 4'h0, 0, 1);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 12'h456, 16'h0000, 4'h0, 0, 0, 16'h9876, 4'h0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 1, 0, 0, 12'h456, 16'h0000, 4'h2, 0, 0, 16'h9876, 4'h0, 0, 0);
    vecs[6]  = mk(0, 1, 1, 0, 1, 1, 12'h456, 16'h9876, 4'h0, 0, 1, 16'h9876, 4'h2, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0, 12'h456, 16'h0000, 4'h0, 0, 0, 16'h9876, 4'h2, 0, 1);
    vecs[8]  = mk(0, 0, 1, 1, 1, 1, 12'h456, 16'h1111, 4'h5, 1, 0, 16'h9876, 4'h2, 0, 1);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 12'h456, 16'h0000, 4'h0, 0, 0, 16'h9876, 4'h2, 0, 1);
    vecs[10] = mk(1, 1, 1, 1, 1, 1, 12'h123, 16'h5555, 4'h7, 0, 1, 16'h0000, 4'h0, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 12'h123, 16'h0000, 4'h0, 0, 0, 16'h1234, 4'h0, 1, 0);
    vecs[12] = mk(0, 1, 0, 0, 0, 0, 12'h456, 16'h0000, 4'h0, 0, 0, 16'hFFFF, 4'h0, 0, 1);
    vecs[13] = mk(0, 1, 0, 0, 1, 0, 12'h456, 16'h0000, 4'h0, 1, 0, 16'hFFFF, 4'h0, 0, 1);
    vecs[14] = mk(0, 1, 0, 0, 1, 0, 12'h123, 16'h0000, 4'h0, 0, 0, 16'h1234, 4'h0, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 12'h456, 16'h0000, 4'h0, 0, 0, 16'hFFFF, 4'h0, 1, 1);
    vecs[16] = mk(0, 1, 0, 0, 0, 0, 12'h123, 16'h0000, 4'h0, 0, 0, 16'h1234, 4'h0, 0, 0);
    vecs[17] = mk(0, 1, 1, 1, 1, 1, 12'hFAB, 16'hABCD, 4'hF, 1, 0, 16'h1234, 4'h0, 0, 0);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 12'hFAB, 16'h0000, 4'h0, 0, 0, 16'hABCD, 4'hF, 1, 0);
    vecs[19] = mk(0, 1, 0, 0, 0, 0, 12'hFAC, 16'h0000, 4'h0, 0, 0, 16'hFFFF, 4'h0, 0, 1);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].cs, vecs[i].prw, vecs[i].crw, vecs[i].arw, vecs[i].lrw,
            vecs[i].addr, vecs[i].pin, vecs[i].cin, vecs[i].ain, vecs[i].lin);
      check($sformatf("vec%0d", i), vecs[i].e_pass, vecs[i].e_count, vecs[i].e_admin, vecs[i].e_lock);
    end

    // Outputs hold while deselected, even with a changing address.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 12'h123 + 12'(i), 16'h0, 4'h0, 0, 0);
      check($sformatf("hold%0d", i), 16'hFFFF, 4'h0, 0, 1);
    end

    // Back-to-back write then read, then reset mid-sequence discards it.
    drive(0, 1, 1, 1, 1, 1, 12'h789, 16'h4321, 4'h3, 1, 1);
    check("wr789", 16'hFFFF, 4'h0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 12'h789, 16'h0, 4'h0, 0, 0);
    check("rd789", 16'h4321, 4'h3, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 12'h789, 16'h0, 4'h0, 0, 0);
    check("rst_mid", 16'h0000, 4'h0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 12'h789, 16'h0, 4'h0, 0, 0);
    check("rd789_post_rst", 16'hFFFF, 4'h0, 0, 1);

    // Randomized traffic against the model, starting from a fresh reset.
    drive(1, 0, 0, 0, 0, 0, 12'h0, 16'h0, 4'h0, 0, 0);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      logic [3:0]  rw;
      case ($urandom_range(0, 3))
        0: a = 12'h123;
        1: a = 12'h456;
        2: a = 12'(12'hFA0 + 12'($urandom_range(0, 3)));
        default: a = 12'($urandom);
      endcase
      rw = 4'($urandom);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
            rw[0], rw[1], rw[2], rw[3], a,
            16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      model_step();
      check($sformatf("rand%0d", i), m_pout, m_cout, m_aout, m_lout);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
